// File: rtl/rv_csr_file.sv
// rv_csr_file: machine-mode CSR unit for the uRV RV32 execute stage.
//
// Executes CSRRW/CSRRS/CSRRC (register and immediate forms) against mstatus,
// mie, mtvec, mscratch, mepc, mcause and mip. It also provides the
// mcycle/minstret counters, level-sensitive external interrupts, trap entry
// and mret handling.
//
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   x_stall_i               execute stage stalled (accesses/retires ignored)
//   d_csr_*                 CSR access request (valid, op, imm, address)
//   d_rs1_i, d_zimm_i       register or immediate operand
//   d_pc_i                  PC saved into mepc on trap entry
//   x_rd_o, x_rd_write_o    old CSR value and rd write enable, one cycle later
//   x_csr_illegal_o         one-cycle pulse for an illegal access
//   x_exception_*_i         trap entry request, interrupt flag and cause id
//   x_mret_i                return from trap
//   x_retire_i              one instruction retired (minstret tick)
//   irq_i                   external interrupt lines, mapped to mip[16+]
//   x_irq_pending_o         enabled interrupt pending while MIE is set
//   x_exception_pc_o        mepc for the fetch stage
//   x_trap_vector_o         mtvec for the fetch stage
module rv_csr_file #(
  parameter int unsigned CNT_W          = 64,
  parameter int unsigned N_IRQ          = 1,
  parameter int unsigned CAUSE_W        = 4,
  parameter logic [31:0] TRAP_VEC_RESET = 32'h8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               x_stall_i,
  input  logic               d_csr_valid_i,
  input  logic [1:0]         d_csr_op_i,
  input  logic               d_csr_imm_i,
  input  logic [11:0]        d_csr_sel_i,
  input  logic [31:0]        d_rs1_i,
  input  logic [4:0]         d_zimm_i,
  input  logic [31:0]        d_pc_i,
  output logic [31:0]        x_rd_o,
  output logic               x_rd_write_o,
  output logic               x_csr_illegal_o,
  input  logic               x_exception_i,
  input  logic               x_exception_irq_i,
  input  logic [CAUSE_W-1:0] x_exception_id_i,
  input  logic               x_mret_i,
  input  logic               x_retire_i,
  input  logic [N_IRQ-1:0]   irq_i,
  output logic               x_irq_pending_o,
  output logic [31:0]        x_exception_pc_o,
  output logic [31:0]        x_trap_vector_o
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;

  // mcause keeps only the interrupt flag and the cause id field
  localparam logic [31:0] CAUSE_MASK = 32'h8000_0000 | ((32'h1 << CAUSE_W) - 32'h1);

  logic               mstatus_mie_q, mstatus_mie_d;
  logic               mstatus_mpie_q, mstatus_mpie_d;
  logic [N_IRQ-1:0]   mie_q, mie_d;
  logic [N_IRQ-1:0]   mip_q, mip_d;
  logic [31:0]        mtvec_q, mtvec_d;
  logic [31:0]        mscratch_q, mscratch_d;
  logic [31:0]        mepc_q, mepc_d;
  logic [31:0]        mcause_q, mcause_d;
  logic [CNT_W-1:0]   mcycle_q, mcycle_d;
  logic [CNT_W-1:0]   minstret_q, minstret_d;
  logic [31:0]        rd_q, rd_d;
  logic               rd_write_q, rd_write_d;
  logic               illegal_q, illegal_d;

  logic [31:0] opnd, old_val, new_val, mie_word, mip_word;
  logic [63:0] cyc64, ins64, cnt_wr64;
  logic        mapped, read_only, access, wr_eff, illegal, discard, do_write;

  // Address decode: old value, whether the address exists, and whether it
  // is read-only. Counters are zero-extended to 64 bits so the high halves
  // read 0 for narrow counters.
  always_comb begin
    cyc64 = '0;
    cyc64[CNT_W-1:0] = mcycle_q;
    ins64 = '0;
    ins64[CNT_W-1:0] = minstret_q;
    mie_word = '0;
    mie_word[16 +: N_IRQ] = mie_q;
    mip_word = '0;
    mip_word[16 +: N_IRQ] = mip_q;
    old_val   = '0;
    mapped    = 1'b1;
    read_only = 1'b0;
    case (d_csr_sel_i)
      A_MSTATUS:   old_val = {24'h0, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
      A_MIE:       old_val = mie_word;
      A_MTVEC:     old_val = mtvec_q;
      A_MSCRATCH:  old_val = mscratch_q;
      A_MEPC:      old_val = mepc_q;
      A_MCAUSE:    old_val = mcause_q;
      A_MIP:       begin old_val = mip_word;     read_only = 1'b1; end
      A_MCYCLE:    old_val = cyc64[31:0];
      A_MCYCLEH:   old_val = cyc64[63:32];
      A_MINSTRET:  old_val = ins64[31:0];
      A_MINSTRETH: old_val = ins64[63:32];
      A_CYCLE:     begin old_val = cyc64[31:0];  read_only = 1'b1; end
      A_CYCLEH:    begin old_val = cyc64[63:32]; read_only = 1'b1; end
      A_INSTRET:   begin old_val = ins64[31:0];  read_only = 1'b1; end
      A_INSTRETH:  begin old_val = ins64[63:32]; read_only = 1'b1; end
      default:     mapped = 1'b0;
    endcase

    opnd = d_csr_imm_i ? {27'h0, d_zimm_i} : d_rs1_i;
    case (d_csr_op_i)
      2'b01:   new_val = opnd;
      2'b10:   new_val = old_val | opnd;
      2'b11:   new_val = old_val & ~opnd;
      default: new_val = old_val;
    endcase

    access   = d_csr_valid_i & (d_csr_op_i != 2'b00) & ~x_stall_i;
    // set/clear with a zero operand is a pure read
    wr_eff   = (d_csr_op_i == 2'b01) | (opnd != 32'h0);
    illegal  = ~mapped | (read_only & wr_eff);
    discard  = x_exception_i | x_mret_i;
    do_write = access & ~illegal & ~discard & wr_eff;
  end

  // Next-state for all CSRs. Counters tick by default and a CSR write to a
  // counter overrides the tick. mret and then trap entry are applied last so
  // they take priority over everything else touching mstatus/mepc/mcause.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mip_d          = irq_i;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mcycle_d       = mcycle_q + CNT_W'(1);
    minstret_d     = minstret_q + CNT_W'(x_retire_i & ~x_stall_i);
    cnt_wr64       = '0;
    rd_d           = rd_q;
    rd_write_d     = rd_write_q;
    illegal_d      = illegal_q;

    if (do_write) begin
      case (d_csr_sel_i)
        A_MSTATUS: begin
          mstatus_mie_d  = new_val[3];
          mstatus_mpie_d = new_val[7];
        end
        A_MIE:      mie_d      = new_val[16 +: N_IRQ];
        A_MTVEC:    mtvec_d    = new_val & 32'hFFFF_FFFC;
        A_MSCRATCH: mscratch_d = new_val;
        A_MEPC:     mepc_d     = new_val & 32'hFFFF_FFFC;
        A_MCAUSE:   mcause_d   = new_val & CAUSE_MASK;
        A_MCYCLE: begin
          cnt_wr64 = {cyc64[63:32], new_val};
          mcycle_d = CNT_W'(cnt_wr64);
        end
        A_MCYCLEH: begin
          cnt_wr64 = {new_val, cyc64[31:0]};
          mcycle_d = CNT_W'(cnt_wr64);
        end
        A_MINSTRET: begin
          cnt_wr64   = {ins64[63:32], new_val};
          minstret_d = CNT_W'(cnt_wr64);
        end
        A_MINSTRETH: begin
          cnt_wr64   = {new_val, ins64[31:0]};
          minstret_d = CNT_W'(cnt_wr64);
        end
        default: ;
      endcase
    end

    if (x_mret_i) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end

    if (x_exception_i) begin
      mepc_d         = d_pc_i & 32'hFFFF_FFFC;
      mcause_d       = {x_exception_irq_i, 31'(x_exception_id_i)};
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end

    // Result outputs freeze while stalled; otherwise write-enable and the
    // illegal flag are single-cycle pulses. rd keeps its last value when
    // no legal access completes.
    if (!x_stall_i) begin
      rd_write_d = 1'b0;
      illegal_d  = 1'b0;
      if (access && !discard) begin
        if (illegal) begin
          illegal_d = 1'b1;
        end else begin
          rd_d       = old_val;
          rd_write_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mip_q          <= '0;
      mtvec_q        <= TRAP_VEC_RESET & 32'hFFFF_FFFC;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
      rd_q           <= '0;
      rd_write_q     <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mip_q          <= mip_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
      rd_q           <= rd_d;
      rd_write_q     <= rd_write_d;
      illegal_q      <= illegal_d;
    end
  end

  assign x_rd_o           = rd_q;
  assign x_rd_write_o     = rd_write_q;
  assign x_csr_illegal_o  = illegal_q;
  assign x_irq_pending_o  = mstatus_mie_q & |(mip_q & mie_q);
  assign x_exception_pc_o = mepc_q;
  assign x_trap_vector_o  = mtvec_q;

endmodule

// File: tb/tb_rv_csr_file.sv
// tb_rv_csr_file: self-checking bench for rv_csr_file.
// Two instances share all inputs: u_dut (CNT_W=64, N_IRQ=2) and u_dut32
// (CNT_W=32, N_IRQ=2), the latter used to check narrow-counter high halves.
module tb_rv_csr_file;

  localparam logic [1:0] OP_N = 2'b00;
  localparam logic [1:0] OP_W = 2'b01;
  localparam logic [1:0] OP_S = 2'b10;
  localparam logic [1:0] OP_C = 2'b11;

  typedef struct packed {
    logic [1:0]  op;
    logic        imm;
    logic [11:0] sel;
    logic [31:0] rs1;
    logic [4:0]  zimm;
    logic        stall;
    logic        retire;
    logic        exc;
    logic        exc_irq;
    logic [3:0]  exc_id;
    logic [31:0] pc;
    logic        mret;
    logic [31:0] exp_rd;
    logic        exp_we;
    logic        exp_ill;
    logic        chk_rd;
    logic        chk32;
    logic [31:0] exp_rd32;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        x_stall_i = 1'b0;
  logic        d_csr_valid_i = 1'b0;
  logic [1:0]  d_csr_op_i = '0;
  logic        d_csr_imm_i = 1'b0;
  logic [11:0] d_csr_sel_i = '0;
  logic [31:0] d_rs1_i = '0;
  logic [4:0]  d_zimm_i = '0;
  logic [31:0] d_pc_i = '0;
  logic        x_exception_i = 1'b0;
  logic        x_exception_irq_i = 1'b0;
  logic [3:0]  x_exception_id_i = '0;
  logic        x_mret_i = 1'b0;
  logic        x_retire_i = 1'b0;
  logic [1:0]  irq_i = '0;

  logic [31:0] x_rd_o, x_exception_pc_o, x_trap_vector_o;
  logic        x_rd_write_o, x_csr_illegal_o, x_irq_pending_o;
  logic [31:0] rd32, epc32, tvec32;
  logic        we32, ill32, pend32;

  int passed = 0;
  int total  = 0;
  int vec_idx = 0;
  vec_t exp_q[$];
  vec_t tbl[28];
  vec_t v;

  always #5 clk_i = ~clk_i;

  rv_csr_file #(.CNT_W(64), .N_IRQ(2), .CAUSE_W(4), .TRAP_VEC_RESET(32'h8)) u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .x_stall_i(x_stall_i),
    .d_csr_valid_i(d_csr_valid_i), .d_csr_op_i(d_csr_op_i), .d_csr_imm_i(d_csr_imm_i),
    .d_csr_sel_i(d_csr_sel_i), .d_rs1_i(d_rs1_i), .d_zimm_i(d_zimm_i), .d_pc_i(d_pc_i),
    .x_rd_o(x_rd_o), .x_rd_write_o(x_rd_write_o), .x_csr_illegal_o(x_csr_illegal_o),
    .x_exception_i(x_exception_i), .x_exception_irq_i(x_exception_irq_i),
    .x_exception_id_i(x_exception_id_i), .x_mret_i(x_mret_i), .x_retire_i(x_retire_i),
    .irq_i(irq_i), .x_irq_pending_o(x_irq_pending_o),
    .x_exception_pc_o(x_exception_pc_o), .x_trap_vector_o(x_trap_vector_o)
  );

  rv_csr_file #(.CNT_W(32), .N_IRQ(2), .CAUSE_W(4), .TRAP_VEC_RESET(32'h8)) u_dut32 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .x_stall_i(x_stall_i),
    .d_csr_valid_i(d_csr_valid_i), .d_csr_op_i(d_csr_op_i), .d_csr_imm_i(d_csr_imm_i),
    .d_csr_sel_i(d_csr_sel_i), .d_rs1_i(d_rs1_i), .d_zimm_i(d_zimm_i), .d_pc_i(d_pc_i),
    .x_rd_o(rd32), .x_rd_write_o(we32), .x_csr_illegal_o(ill32),
    .x_exception_i(x_exception_i), .x_exception_irq_i(x_exception_irq_i),
    .x_exception_id_i(x_exception_id_i), .x_mret_i(x_mret_i), .x_retire_i(x_retire_i),
    .irq_i(irq_i), .x_irq_pending_o(pend32),
    .x_exception_pc_o(epc32), .x_trap_vector_o(tvec32)
  );

  function automatic vec_t mk(input logic [1:0] op, input logic imm, input logic [11:0] sel,
                              input logic [31:0] rs1, input logic [4:0] zimm,
                              input logic [31:0] exp_rd, input logic exp_we,
                              input logic exp_ill, input logic chk_rd);
    vec_t r;
    r = '0;
    r.op = op; r.imm = imm; r.sel = sel; r.rs1 = rs1; r.zimm = zimm;
    r.exp_rd = exp_rd; r.exp_we = exp_we; r.exp_ill = exp_ill; r.chk_rd = chk_rd;
    return r;
  endfunction

  function automatic vec_t with32(input vec_t in, input logic [31:0] exp32);
    vec_t r;
    r = in;
    r.chk32 = 1'b1;
    r.exp_rd32 = exp32;
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else
      passed++;
  endtask

  // Pops the expected record for the access that just completed
  task automatic checkOutput();
    vec_t e;
    if (exp_q.size() == 0) begin
      total++;
      $display("[TB] FAIL scoreboard_empty: got no entry, expected one");
      return;
    end
    e = exp_q.pop_front();
    checkVal($sformatf("vec%0d_we", vec_idx), 32'(x_rd_write_o), 32'(e.exp_we));
    checkVal($sformatf("vec%0d_ill", vec_idx), 32'(x_csr_illegal_o), 32'(e.exp_ill));
    if (e.chk_rd) checkVal($sformatf("vec%0d_rd", vec_idx), x_rd_o, e.exp_rd);
    if (e.chk32) checkVal($sformatf("vec%0d_rd32", vec_idx), rd32, e.exp_rd32);
    vec_idx++;
  endtask

  // Drives one cycle of stimulus on the falling edge, samples after the rise
  task automatic applyStimulus(input vec_t s);
    @(negedge clk_i);
    d_csr_valid_i     = 1'b1;
    d_csr_op_i        = s.op;
    d_csr_imm_i       = s.imm;
    d_csr_sel_i       = s.sel;
    d_rs1_i           = s.rs1;
    d_zimm_i          = s.zimm;
    x_stall_i         = s.stall;
    x_retire_i        = s.retire;
    x_exception_i     = s.exc;
    x_exception_irq_i = s.exc_irq;
    x_exception_id_i  = s.exc_id;
    d_pc_i            = s.pc;
    x_mret_i          = s.mret;
    exp_q.push_back(s);
    @(posedge clk_i);
    #1;
    checkOutput();
  endtask

  initial begin
    // Access program; each entry depends on the state left by the previous ones
    tbl[0]  = mk(OP_W, 0, 12'h340, 32'hDEADBEEF, 0, 32'h0,        1, 0, 1);
    tbl[1]  = mk(OP_S, 0, 12'h340, 32'h0,        0, 32'hDEADBEEF, 1, 0, 1);
    tbl[2]  = mk(OP_S, 1, 12'h300, 32'h0,        8, 32'h0,        1, 0, 1);
    tbl[3]  = mk(OP_C, 1, 12'h300, 32'h0,        8, 32'h8,        1, 0, 1);
    tbl[4]  = mk(OP_S, 1, 12'h300, 32'h0,        0, 32'h0,        1, 0, 1);
    tbl[5]  = mk(OP_W, 0, 12'h305, 32'h1003,     0, 32'h8,        1, 0, 1);
    tbl[6]  = mk(OP_S, 0, 12'h305, 32'h0,        0, 32'h1000,     1, 0, 1);
    tbl[7]  = mk(OP_W, 0, 12'hC00, 32'h5,        0, 32'h0,        0, 1, 0);
    tbl[8]  = mk(OP_W, 0, 12'h7FF, 32'h5,        0, 32'h0,        0, 1, 0);
    tbl[9]  = mk(OP_S, 1, 12'h344, 32'h0,        0, 32'h0,        1, 0, 1);
    tbl[10] = mk(OP_S, 1, 12'h344, 32'h0,        1, 32'h0,        0, 1, 0);
    tbl[11] = mk(OP_W, 0, 12'h341, 32'h103,      0, 32'h0,        1, 0, 1);
    tbl[12] = mk(OP_C, 0, 12'h341, 32'h0,        0, 32'h100,      1, 0, 1);
    tbl[13] = mk(OP_W, 0, 12'h304, 32'hFFFFFFFF, 0, 32'h0,        1, 0, 1);
    tbl[14] = mk(OP_S, 0, 12'h304, 32'h0,        0, 32'h30000,    1, 0, 1);
    tbl[15] = mk(OP_N, 0, 12'h340, 32'h1,        0, 32'h0,        0, 0, 0);
    tbl[16] = mk(OP_W, 0, 12'hB00, 32'hFFFFFFFF, 0, 32'h0,        1, 0, 0);
    tbl[17] = mk(OP_W, 0, 12'hB80, 32'hFFFFFFFF, 0, 32'h0,        1, 0, 0);
    tbl[18] = with32(mk(OP_S, 0, 12'hB80, 32'h0, 0, 32'hFFFFFFFF, 1, 0, 1), 32'h0);
    tbl[19] = mk(OP_S, 0, 12'hB00, 32'h0,        0, 32'h0,        1, 0, 1);
    tbl[20] = with32(mk(OP_S, 0, 12'hB80, 32'h0, 0, 32'h0,        1, 0, 1), 32'h0);
    tbl[21] = mk(OP_W, 0, 12'hB02, 32'h5,        0, 32'h0,        1, 0, 0);
    tbl[22] = with32(mk(OP_S, 0, 12'hB02, 32'h0, 0, 32'h5,        1, 0, 1), 32'h5);
    tbl[23] = with32(mk(OP_S, 1, 12'hC02, 32'h0, 0, 32'h5,        1, 0, 1), 32'h5);
    tbl[24] = with32(mk(OP_C, 1, 12'hC80, 32'h0, 0, 32'h0,        1, 0, 1), 32'h0);
    tbl[25] = mk(OP_W, 0, 12'hC00, 32'h0,        0, 32'h0,        0, 1, 0);
    tbl[26] = mk(OP_W, 0, 12'hC02, 32'h9,        0, 32'h0,        0, 1, 0);
    tbl[27] = mk(OP_S, 0, 12'hB02, 32'h0,        0, 32'h5,        1, 0, 1);

    // Reset state
    #12;
    checkVal("rst_rd", x_rd_o, 32'h0);
    checkVal("rst_we", 32'(x_rd_write_o), 32'h0);
    checkVal("rst_ill", 32'(x_csr_illegal_o), 32'h0);
    checkVal("rst_pend", 32'(x_irq_pending_o), 32'h0);
    checkVal("rst_mepc", x_exception_pc_o, 32'h0);
    checkVal("rst_mtvec", x_trap_vector_o, 32'h8);
    checkVal("rst_mtvec32", tvec32, 32'h8);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    for (int i = 0; i < 28; i++) applyStimulus(tbl[i]);
    checkVal("mtvec_out", x_trap_vector_o, 32'h1000);

    // Interrupt pending: mie = 0x30000 from the table, set MIE, raise irq[1]
    applyStimulus(mk(OP_S, 1, 12'h300, 32'h0, 8, 32'h0, 1, 0, 1));
    checkVal("pend_noirq", 32'(x_irq_pending_o), 32'h0);
    @(negedge clk_i);
    d_csr_valid_i = 1'b0;
    irq_i = 2'b10;
    #1;
    checkVal("pend_before_reg", 32'(x_irq_pending_o), 32'h0);
    @(posedge clk_i);
    #1;
    checkVal("pend_after_reg", 32'(x_irq_pending_o), 32'h1);
    applyStimulus(mk(OP_S, 1, 12'h344, 32'h0, 0, 32'h20000, 1, 0, 1));
    applyStimulus(mk(OP_C, 1, 12'h300, 32'h0, 8, 32'h8, 1, 0, 1));
    checkVal("pend_mie_off", 32'(x_irq_pending_o), 32'h0);
    irq_i = 2'b00;

    // Trap entry with MIE=1, then mret
    applyStimulus(mk(OP_S, 1, 12'h300, 32'h0, 8, 32'h0, 1, 0, 1));
    v = mk(OP_N, 0, 12'h0, 32'h0, 0, 32'h0, 0, 0, 0);
    v.exc = 1; v.exc_id = 4'd2; v.pc = 32'h244;
    applyStimulus(v);
    checkVal("trap_mepc", x_exception_pc_o, 32'h244);
    applyStimulus(mk(OP_S, 1, 12'h342, 32'h0, 0, 32'h2, 1, 0, 1));
    applyStimulus(mk(OP_S, 1, 12'h300, 32'h0, 0, 32'h80, 1, 0, 1));
    v = mk(OP_N, 0, 12'h0, 32'h0, 0, 32'h0, 0, 0, 0);
    v.mret = 1;
    applyStimulus(v);
    applyStimulus(mk(OP_S, 1, 12'h300, 32'h0, 0, 32'h88, 1, 0, 1));

    // Exception and mret each discard a same-cycle CSR write
    v = mk(OP_W, 0, 12'h340, 32'h1234, 0, 32'h0, 0, 0, 0);
    v.exc = 1; v.exc_irq = 1; v.exc_id = 4'd3; v.pc = 32'h400;
    applyStimulus(v);
    applyStimulus(mk(OP_S, 0, 12'h340, 32'h0, 0, 32'hDEADBEEF, 1, 0, 1));
    applyStimulus(mk(OP_S, 0, 12'h342, 32'h0, 0, 32'h80000003, 1, 0, 1));
    applyStimulus(mk(OP_S, 1, 12'h300, 32'h0, 0, 32'h80, 1, 0, 1));
    v = mk(OP_W, 0, 12'h340, 32'h77, 0, 32'h0, 0, 0, 0);
    v.mret = 1;
    applyStimulus(v);
    applyStimulus(mk(OP_S, 0, 12'h340, 32'h0, 0, 32'hDEADBEEF, 1, 0, 1));
    applyStimulus(mk(OP_S, 1, 12'h300, 32'h0, 0, 32'h88, 1, 0, 1));

    // Stall holds outputs and ignores the access; trap entry still happens
    v = mk(OP_W, 0, 12'h340, 32'h55, 0, 32'h88, 1, 0, 1);
    v.stall = 1; v.retire = 1; v.exc = 1; v.exc_id = 4'd5; v.pc = 32'h300;
    applyStimulus(v);
    checkVal("stall_trap_mepc", x_exception_pc_o, 32'h300);
    applyStimulus(mk(OP_S, 0, 12'h340, 32'h0, 0, 32'hDEADBEEF, 1, 0, 1));

    // minstret counts unstalled retires only
    applyStimulus(mk(OP_W, 0, 12'hB02, 32'h0, 0, 32'h5, 1, 0, 1));
    for (int i = 0; i < 3; i++) begin
      v = mk(OP_N, 0, 12'h0, 32'h0, 0, 32'h0, 0, 0, 0);
      v.retire = 1;
      applyStimulus(v);
    end
    v = mk(OP_N, 0, 12'h0, 32'h0, 0, 32'h0, 0, 0, 0);
    v.retire = 1; v.stall = 1;
    applyStimulus(v);
    applyStimulus(with32(mk(OP_S, 0, 12'hB02, 32'h0, 0, 32'h3, 1, 0, 1), 32'h3));

    // Illegal flag is a single-cycle pulse
    applyStimulus(mk(OP_W, 0, 12'h7FF, 32'h0, 0, 32'h0, 0, 1, 0));
    applyStimulus(mk(OP_N, 0, 12'h0, 32'h0, 0, 32'h0, 0, 0, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
